// File: rtl/reg_file_sb.sv
// reg_file_sb: 32-entry integer register file with a write-first read bypass
// and a pending-write scoreboard for load/JAL results. The read side serves
// decode. The write side is fed by write-back. The issue side marks
// destinations that are still in flight.
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWE,
   input  logic [4:0]      RegWA,
   input  logic [XLEN-1:0] RegWD,
   input  logic [4:0]      RA1,
   input  logic [4:0]      RA2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic            Busy1,
   output logic            Busy2,
   input  logic            IssueValid,
   input  logic [4:0]      IssueRd,
   input  logic            Flush
);

   // Register contents as seen by the read muxes. Entry 0 is hard-wired to zero.
   logic [XLEN-1:0] w_regs [NREG];

   // One-hot write and issue decodes. Bit 0 is masked so that x0 is never
   // written and never marked pending.
   logic [NREG-1:0] w_wr_dec;
   logic [NREG-1:0] w_iss_dec;

   // Scoreboard. Bit 0 exists only to simplify indexing and stays zero.
   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] r_pending_next;

   assign w_regs[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_dec
         if (gi == 0) begin : g_zero
            assign w_wr_dec[gi]  = 1'b0;
            assign w_iss_dec[gi] = 1'b0;
         end else begin : g_nz
            assign w_wr_dec[gi]  = RegWE      && (RegWA   == 5'(gi));
            assign w_iss_dec[gi] = IssueValid && (IssueRd == 5'(gi));
         end
      end

      for (gi = 1; gi < NREG; gi++) begin : g_reg
         logic [XLEN-1:0] r_reg;

         // Architectural register gi; async clear, write when addressed by write-back
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_reg <= '0;
            end else if (w_wr_dec[gi]) begin
               r_reg <= RegWD;
            end
         end

         assign w_regs[gi] = r_reg;
      end
   endgenerate

   // Scoreboard next state: flush clears everything; otherwise a write-back
   // clears its bit, and an issue sets its bit. Set wins on a collision
   // because the newer producer is still outstanding.
   always_comb begin
      r_pending_next = r_pending;
      if (Flush) begin
         r_pending_next = '0;
      end else begin
         r_pending_next = (r_pending & ~w_wr_dec) | w_iss_dec;
      end
      r_pending_next[0] = 1'b0;
   end

   // Scoreboard state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= r_pending_next;
      end
   end

   // Read ports with write-first bypass. A same-cycle write-back also
   // releases the stall, because the bypass already supplies the data.
   always_comb begin
      RD1   = '0;
      RD2   = '0;
      Busy1 = 1'b0;
      Busy2 = 1'b0;
      if (RA1 != 5'd0) begin
         if (RegWE && (RegWA == RA1)) begin
            RD1 = RegWD;
         end else begin
            RD1   = w_regs[RA1];
            Busy1 = r_pending[RA1];
         end
      end
      if (RA2 != 5'd0) begin
         if (RegWE && (RegWA == RA2)) begin
            RD2 = RegWD;
         end else begin
            RD2   = w_regs[RA2];
            Busy2 = r_pending[RA2];
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed test of the register file, the read bypass,
// the scoreboard, flush, and the asynchronous reset.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;
   logic        RegWE;
   logic [4:0]  RegWA;
   logic [31:0] RegWD;
   logic [4:0]  RA1;
   logic [4:0]  RA2;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic        Busy1;
   logic        Busy2;
   logic        IssueValid;
   logic [4:0]  IssueRd;
   logic        Flush;

   int passed = 0;
   int total  = 0;

   reg_file_sb #(.XLEN(32), .NREG(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RegWE      (RegWE),
      .RegWA      (RegWA),
      .RegWD      (RegWD),
      .RA1        (RA1),
      .RA2        (RA2),
      .RD1        (RD1),
      .RD2        (RD2),
      .Busy1      (Busy1),
      .Busy2      (Busy2),
      .IssueValid (IssueValid),
      .IssueRd    (IssueRd),
      .Flush      (Flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegWE      = 1'b0;
      RegWA      = 5'd0;
      RegWD      = 32'd0;
      IssueValid = 1'b0;
      IssueRd    = 5'd0;
      Flush      = 1'b0;
   endtask

   task automatic test_reset();
      int ras [4] = '{0, 1, 5, 31};
      rst_n = 1'b0;
      idle();
      #2;
      foreach (ras[i]) begin
         RA1 = 5'(ras[i]);
         RA2 = 5'(ras[i]);
         #1;
         total++;
         if (RD1 !== 32'd0 || RD2 !== 32'd0 || Busy1 !== 1'b0 || Busy2 !== 1'b0)
            $display("FAIL reset ra=%0d: RD1=%h RD2=%h Busy1=%b Busy2=%b, need all 0",
                     ras[i], RD1, RD2, Busy1, Busy2);
         else begin
            passed++;
            $display("reset ra=%0d ok", ras[i]);
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      RA1 = 5'd0; RA2 = 5'd5;
      RegWE = 1'b1; RegWA = 5'd5; RegWD = 32'hDEADBEEF;
      #1;
      total++;
      if (RD2 !== 32'hDEADBEEF) $display("FAIL bypass_rd2: got %h need deadbeef", RD2);
      else begin passed++; $display("bypass RD2=%h", RD2); end
      tick();
      idle();
      RA1 = 5'd5;
      #1;
      total++;
      if (RD1 !== 32'hDEADBEEF) $display("FAIL write_read_rd1: got %h need deadbeef", RD1);
      else begin passed++; $display("read r5 RD1=%h", RD1); end
   endtask

   task automatic test_x0();
      RegWE = 1'b1; RegWA = 5'd0; RegWD = 32'h1234; RA1 = 5'd0;
      #1;
      total++;
      if (RD1 !== 32'd0) $display("FAIL x0_bypass: got %h need 0", RD1);
      else begin passed++; $display("x0 bypass RD1=%h", RD1); end
      tick();
      idle();
      IssueValid = 1'b1; IssueRd = 5'd0;
      #1;
      total++;
      if (RD1 !== 32'd0) $display("FAIL x0_read: got %h need 0", RD1);
      else begin passed++; $display("x0 read RD1=%h", RD1); end
      tick();
      idle();
      #1;
      total++;
      if (Busy1 !== 1'b0) $display("FAIL x0_busy: got %b need 0", Busy1);
      else begin passed++; $display("x0 busy=%b", Busy1); end
   endtask

   task automatic test_scoreboard();
      IssueValid = 1'b1; IssueRd = 5'd7; RA1 = 5'd7;
      #1;
      total++;
      if (Busy1 !== 1'b0) $display("FAIL sb_pre_issue: got %b need 0", Busy1);
      else begin passed++; $display("sb before edge busy=%b", Busy1); end
      tick();
      idle();
      #1;
      total++;
      if (Busy1 !== 1'b1) $display("FAIL sb_marked: got %b need 1", Busy1);
      else begin passed++; $display("sb marked busy=%b", Busy1); end
      tick();
      tick();
      total++;
      if (Busy1 !== 1'b1) $display("FAIL sb_hold: got %b need 1", Busy1);
      else begin passed++; $display("sb hold busy=%b", Busy1); end
      RegWE = 1'b1; RegWA = 5'd7; RegWD = 32'hA5;
      #1;
      total++;
      if (Busy1 !== 1'b0 || RD1 !== 32'hA5)
         $display("FAIL sb_wb_same_cycle: Busy1=%b RD1=%h need 0/a5", Busy1, RD1);
      else begin passed++; $display("sb wb same cycle busy=%b RD1=%h", Busy1, RD1); end
      tick();
      idle();
      #1;
      total++;
      if (Busy1 !== 1'b0 || RD1 !== 32'hA5)
         $display("FAIL sb_cleared: Busy1=%b RD1=%h need 0/a5", Busy1, RD1);
      else begin passed++; $display("sb cleared busy=%b RD1=%h", Busy1, RD1); end
   endtask

   task automatic test_simultaneous();
      IssueValid = 1'b1; IssueRd = 5'd9;
      tick();
      idle();
      IssueValid = 1'b1; IssueRd = 5'd9;
      RegWE = 1'b1; RegWA = 5'd9; RegWD = 32'h99;
      tick();
      idle();
      RA1 = 5'd9;
      #1;
      total++;
      if (Busy1 !== 1'b1 || RD1 !== 32'h99)
         $display("FAIL set_wins: Busy1=%b RD1=%h need 1/99", Busy1, RD1);
      else begin passed++; $display("set wins busy=%b RD1=%h", Busy1, RD1); end
      IssueValid = 1'b1; IssueRd = 5'd4;
      tick();
      idle();
      IssueValid = 1'b1; IssueRd = 5'd3;
      RegWE = 1'b1; RegWA = 5'd4; RegWD = 32'h44;
      tick();
      idle();
      RA1 = 5'd3; RA2 = 5'd4;
      #1;
      total++;
      if (Busy1 !== 1'b1 || Busy2 !== 1'b0 || RD2 !== 32'h44)
         $display("FAIL set_clear_split: Busy1=%b Busy2=%b RD2=%h need 1/0/44",
                  Busy1, Busy2, RD2);
      else begin passed++; $display("split set/clear busy1=%b busy2=%b", Busy1, Busy2); end
   endtask

   task automatic test_flush();
      IssueValid = 1'b1; IssueRd = 5'd8;
      tick();
      idle();
      RA1 = 5'd3; RA2 = 5'd8;
      #1;
      total++;
      if (Busy1 !== 1'b1 || Busy2 !== 1'b1)
         $display("FAIL flush_pre: Busy1=%b Busy2=%b need 1/1", Busy1, Busy2);
      else begin passed++; $display("pre flush busy1=%b busy2=%b", Busy1, Busy2); end
      Flush = 1'b1; IssueValid = 1'b1; IssueRd = 5'd10;
      tick();
      idle();
      #1;
      total++;
      if (Busy1 !== 1'b0 || Busy2 !== 1'b0)
         $display("FAIL flush_clear: Busy1=%b Busy2=%b need 0/0", Busy1, Busy2);
      else begin passed++; $display("flush busy1=%b busy2=%b", Busy1, Busy2); end
      RA1 = 5'd10; RA2 = 5'd9;
      #1;
      total++;
      if (Busy1 !== 1'b0 || Busy2 !== 1'b0)
         $display("FAIL flush_override: Busy1=%b Busy2=%b need 0/0", Busy1, Busy2);
      else begin passed++; $display("flush r10/r9 busy1=%b busy2=%b", Busy1, Busy2); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int i = 0; i < 4; i++) begin
         RegWE = 1'b1; RegWA = 5'(i + 1); RegWD = vals[i];
         tick();
      end
      idle();
      for (int i = 0; i < 4; i += 2) begin
         RA1 = 5'(i + 1); RA2 = 5'(i + 2);
         #1;
         total++;
         if (RD1 !== vals[i] || RD2 !== vals[i+1])
            $display("FAIL b2b r%0d/r%0d: got %h/%h need %h/%h",
                     i + 1, i + 2, RD1, RD2, vals[i], vals[i+1]);
         else begin passed++; $display("b2b r%0d=%h r%0d=%h", i + 1, RD1, i + 2, RD2); end
      end
   endtask

   task automatic test_async_reset();
      IssueValid = 1'b1; IssueRd = 5'd12;
      tick();
      idle();
      RA1 = 5'd12; RA2 = 5'd5;
      #1;
      total++;
      if (Busy1 !== 1'b1 || RD2 !== 32'hDEADBEEF)
         $display("FAIL arst_pre: Busy1=%b RD2=%h need 1/deadbeef", Busy1, RD2);
      else begin passed++; $display("pre arst busy1=%b RD2=%h", Busy1, RD2); end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (Busy1 !== 1'b0 || RD2 !== 32'd0)
         $display("FAIL arst_immediate: Busy1=%b RD2=%h need 0/0", Busy1, RD2);
      else begin passed++; $display("arst busy1=%b RD2=%h", Busy1, RD2); end
      rst_n = 1'b1;
      tick();
      RA1 = 5'd7;
      #1;
      total++;
      if (Busy1 !== 1'b0 || RD1 !== 32'd0 || RD2 !== 32'd0)
         $display("FAIL arst_after: Busy1=%b RD1=%h RD2=%h need 0/0/0", Busy1, RD1, RD2);
      else begin passed++; $display("post arst busy1=%b RD1=%h RD2=%h", Busy1, RD1, RD2); end
   endtask

   initial begin
      RA1 = 5'd0;
      RA2 = 5'd0;
      test_reset();
      test_write_read();
      test_x0();
      test_scoreboard();
      test_simultaneous();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
